// File: rtl/line_buf_ctrl.sv
// Line-buffer sequencing controller for a 3-bank line SRAM: CNN fill/stream/drain
// passes and full-connect write-then-read, with one-cycle handshake pulses to the SRAM side.
module line_buf_ctrl #(
  parameter int unsigned AW = 10
) (
  input  logic          SYS_CLK,
  input  logic          SYS_RST,
  input  logic [3:0]    mode_i,
  input  logic          start_i,
  input  logic [7:0]    pic_size_i,
  input  logic          pix_vld_i,
  output logic          pix_rdy_o,
  input  logic          rd_ready_i,
  output logic [AW+1:0] waddr_o,
  output logic          wdata_vld_o,
  output logic [AW+1:0] raddr_o,
  output logic          raddr_vld_o,
  output logic          data_sop_o,
  output logic          data_eop_o,
  output logic          wsram_2line_o,
  output logic          r2wrsram_o,
  output logic          wrsram_bank_change_o,
  output logic          wr2rsram_o,
  output logic          rsram2idle_o,
  output logic          busy_o,
  output logic          err_o
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFill   = 3'd1;
  localparam logic [2:0] StStream = 3'd2;
  localparam logic [2:0] StDrain  = 3'd3;
  localparam logic [2:0] StFcWr   = 3'd4;
  localparam logic [2:0] StFcRd   = 3'd5;

  function automatic logic [1:0] inc3(input logic [1:0] b);
    return (b == 2'd2) ? 2'd0 : b + 2'd1;
  endfunction

  logic [2:0] state_q, state_d;
  logic [7:0] n_q, n_d;
  logic [7:0] lw_q, lw_d;
  logic [1:0] wbank_q, wbank_d;
  logic [8:0] wcnt_q, wcnt_d;
  logic [9:0] rcnt_q, rcnt_d;
  logic sop_q, sop_d, eop_q, eop_d, w2l_q, w2l_d, r2w_q, r2w_d;
  logic bchg_q, bchg_d, wr2r_q, wr2r_d, idle_q, idle_d, err_q, err_d;

  logic       pulse_any, wr_state, rd_state, wr_fire, rd_fire, rhalf;
  logic       is_cnn, is_fc, cnn_ok;
  logic [8:0] two_n, wq, wcnt_inc, wnext;
  logic [9:0] four_n, rq, rcnt_inc, rnext, roff;
  logic [1:0] rbank;

  assign two_n    = {n_q, 1'b0};
  assign four_n   = {n_q, 2'b00};
  assign wcnt_inc = wcnt_q + 9'd1;
  assign rcnt_inc = rcnt_q + 10'd1;

  // Writes and reads are both frozen during any sequencing pulse cycle.
  assign pulse_any = sop_q | eop_q | w2l_q | r2w_q | bchg_q | wr2r_q | idle_q;
  assign wr_state  = (state_q == StFill) || (state_q == StStream) || (state_q == StFcWr);
  assign rd_state  = (state_q == StStream) || (state_q == StDrain) || (state_q == StFcRd);
  assign wq        = (state_q == StFcWr) ? {1'b0, n_q} : two_n;
  assign rq        = (state_q == StFcRd) ? {2'b00, n_q} : four_n;

  assign pix_rdy_o   = wr_state && (wcnt_q < wq) && !pulse_any;
  assign wr_fire     = pix_vld_i & pix_rdy_o;
  assign wdata_vld_o = wr_fire;
  assign rd_fire     = rd_ready_i && rd_state && (rcnt_q < rq) && !pulse_any;
  assign raddr_vld_o = rd_fire;

  // Each bank holds two lines, so the in-bank offset is just the count within the half.
  assign rhalf = (rcnt_q >= {1'b0, two_n});
  assign roff  = rhalf ? rcnt_q - {1'b0, two_n} : rcnt_q;

  always_comb begin
    rbank = 2'd0;
    case (state_q)
      StStream: rbank = rhalf ? inc3(inc3(wbank_q)) : inc3(wbank_q);
      StDrain:  rbank = rhalf ? wbank_q : inc3(inc3(wbank_q));
      default:  rbank = 2'd0;
    endcase
  end

  assign waddr_o = {wbank_q, AW'(wcnt_q)};
  assign raddr_o = {rbank, AW'(roff)};

  assign is_cnn = |mode_i[2:0];
  assign is_fc  = mode_i[3] && !is_cnn;
  assign cnn_ok = !pic_size_i[0] && (pic_size_i >= 8'd6) && (pic_size_i <= 8'd254);

  assign wnext = wr_fire ? wcnt_inc : wcnt_q;
  assign rnext = rd_fire ? rcnt_inc : rcnt_q;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    lw_d    = lw_q;
    wbank_d = wbank_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    w2l_d   = 1'b0;
    r2w_d   = 1'b0;
    bchg_d  = 1'b0;
    wr2r_d  = 1'b0;
    idle_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          wbank_d = 2'd0;
          wcnt_d  = 9'd0;
          rcnt_d  = 10'd0;
          lw_d    = 8'd0;
          if (is_cnn && cnn_ok) begin
            n_d     = pic_size_i;
            sop_d   = 1'b1;
            state_d = StFill;
          end else if (is_fc && (pic_size_i != 8'd0)) begin
            n_d     = pic_size_i;
            sop_d   = 1'b1;
            state_d = StFcWr;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StFill: begin
        if (wr_fire) begin
          if (wcnt_inc == two_n) begin
            wcnt_d = 9'd0;
            if (wbank_q == 2'd0) begin
              wbank_d = 2'd1;
              w2l_d   = 1'b1;
            end else begin
              wbank_d = 2'd2;
              r2w_d   = 1'b1;
              lw_d    = 8'd4;
              rcnt_d  = 10'd0;
              state_d = StStream;
            end
          end else begin
            wcnt_d = wcnt_inc;
          end
        end
      end
      StStream: begin
        if ((wnext == two_n) && (rnext == four_n)) begin
          lw_d   = lw_q + 8'd2;
          wcnt_d = 9'd0;
          rcnt_d = 10'd0;
          if (lw_q + 8'd2 == n_q) begin
            wr2r_d  = 1'b1;
            state_d = StDrain;
          end else begin
            bchg_d  = 1'b1;
            wbank_d = inc3(wbank_q);
          end
        end else begin
          wcnt_d = wnext;
          rcnt_d = rnext;
        end
      end
      StDrain, StFcRd: begin
        if (rd_fire) begin
          if (rcnt_inc == rq) begin
            idle_d  = 1'b1;
            state_d = StIdle;
            wbank_d = 2'd0;
            wcnt_d  = 9'd0;
            rcnt_d  = 10'd0;
            lw_d    = 8'd0;
          end else begin
            rcnt_d = rcnt_inc;
          end
        end
      end
      StFcWr: begin
        if (wr_fire) begin
          if (wcnt_inc == {1'b0, n_q}) begin
            eop_d   = 1'b1;
            wcnt_d  = 9'd0;
            rcnt_d  = 10'd0;
            state_d = StFcRd;
          end else begin
            wcnt_d = wcnt_inc;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      state_q <= StIdle;
      n_q     <= 8'd0;
      lw_q    <= 8'd0;
      wbank_q <= 2'd0;
      wcnt_q  <= 9'd0;
      rcnt_q  <= 10'd0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      w2l_q   <= 1'b0;
      r2w_q   <= 1'b0;
      bchg_q  <= 1'b0;
      wr2r_q  <= 1'b0;
      idle_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      lw_q    <= lw_d;
      wbank_q <= wbank_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      w2l_q   <= w2l_d;
      r2w_q   <= r2w_d;
      bchg_q  <= bchg_d;
      wr2r_q  <= wr2r_d;
      idle_q  <= idle_d;
      err_q   <= err_d;
    end
  end

  assign data_sop_o           = sop_q;
  assign data_eop_o           = eop_q;
  assign wsram_2line_o        = w2l_q;
  assign r2wrsram_o           = r2w_q;
  assign wrsram_bank_change_o = bchg_q;
  assign wr2rsram_o           = wr2r_q;
  assign rsram2idle_o         = idle_q;
  assign busy_o               = (state_q != StIdle);
  assign err_o                = err_q;

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Bench for line_buf_ctrl: start-vector table, randomized handshakes scored against an
// event-order model of writes, reads and sequencing pulses, plus stall and reset sequences.
module tb_line_buf_ctrl;
  localparam int AW = 10;

  logic          SYS_CLK = 1'b0;
  logic          SYS_RST;
  logic [3:0]    mode_i;
  logic          start_i;
  logic [7:0]    pic_size_i;
  logic          pix_vld_i;
  logic          pix_rdy_o;
  logic          rd_ready_i;
  logic [AW+1:0] waddr_o;
  logic          wdata_vld_o;
  logic [AW+1:0] raddr_o;
  logic          raddr_vld_o;
  logic          data_sop_o, data_eop_o, wsram_2line_o, r2wrsram_o;
  logic          wrsram_bank_change_o, wr2rsram_o, rsram2idle_o, busy_o, err_o;

  line_buf_ctrl #(.AW(AW)) dut (
    .SYS_CLK(SYS_CLK), .SYS_RST(SYS_RST), .mode_i(mode_i), .start_i(start_i),
    .pic_size_i(pic_size_i), .pix_vld_i(pix_vld_i), .pix_rdy_o(pix_rdy_o),
    .rd_ready_i(rd_ready_i), .waddr_o(waddr_o), .wdata_vld_o(wdata_vld_o),
    .raddr_o(raddr_o), .raddr_vld_o(raddr_vld_o), .data_sop_o(data_sop_o),
    .data_eop_o(data_eop_o), .wsram_2line_o(wsram_2line_o), .r2wrsram_o(r2wrsram_o),
    .wrsram_bank_change_o(wrsram_bank_change_o), .wr2rsram_o(wr2rsram_o),
    .rsram2idle_o(rsram2idle_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  int checks = 0;
  int errors = 0;

  int obs_w[$], obs_r[$], obs_p[$];
  int exp_w[$], exp_r[$], exp_p[$];
  bit mon_en = 1'b0;
  int gap_viol, strb_viol, rdy_viol, err_cnt, idle_cnt, r2w_cnt;

  // Pulse id, writes seen before it, reads seen before it.
  function automatic int enc(input int id, input int wc, input int rc);
    return (id << 22) | (wc << 11) | rc;
  endfunction

  always @(negedge SYS_CLK) begin
    if (mon_en) begin
      int wc, rc;
      wc = obs_w.size();
      rc = obs_r.size();
      if (data_sop_o)           obs_p.push_back(enc(1, wc, rc));
      if (wsram_2line_o)        obs_p.push_back(enc(2, wc, rc));
      if (r2wrsram_o)           begin obs_p.push_back(enc(3, wc, rc)); r2w_cnt++; end
      if (wrsram_bank_change_o) obs_p.push_back(enc(4, wc, rc));
      if (wr2rsram_o)           obs_p.push_back(enc(5, wc, rc));
      if (data_eop_o)           obs_p.push_back(enc(6, wc, rc));
      if (rsram2idle_o)         begin obs_p.push_back(enc(7, wc, rc)); idle_cnt++; end
      if (err_o) err_cnt++;
      if ((data_sop_o | data_eop_o | wsram_2line_o | r2wrsram_o | wrsram_bank_change_o |
           wr2rsram_o | rsram2idle_o) && (wdata_vld_o || raddr_vld_o)) gap_viol++;
      if (wdata_vld_o !== (pix_vld_i & pix_rdy_o)) strb_viol++;
      if (raddr_vld_o && !rd_ready_i) rdy_viol++;
      if (wdata_vld_o) obs_w.push_back(int'(waddr_o));
      if (raddr_vld_o) obs_r.push_back(int'(raddr_o));
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_q(input string name, input int a[$], input int e[$]);
    int bad;
    bad = -1;
    chk({name, " length"}, a.size(), e.size());
    for (int i = 0; i < a.size() && i < e.size(); i++)
      if (bad < 0 && a[i] != e[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, bad, a[bad], e[bad]);
    end
  endtask

  // Expected event order derived from the bank rotation rules.
  task automatic build_model(input bit cnn, input int n);
    int wb, lw, wt, rt;
    exp_w.delete(); exp_r.delete(); exp_p.delete();
    exp_p.push_back(enc(1, 0, 0));
    if (!cnn) begin
      for (int o = 0; o < n; o++) exp_w.push_back(o);
      exp_p.push_back(enc(6, n, 0));
      for (int o = 0; o < n; o++) exp_r.push_back(o);
      exp_p.push_back(enc(7, n, n));
      return;
    end
    for (int o = 0; o < 2 * n; o++) exp_w.push_back(o);
    exp_p.push_back(enc(2, 2 * n, 0));
    for (int o = 0; o < 2 * n; o++) exp_w.push_back((1 << AW) | o);
    exp_p.push_back(enc(3, 4 * n, 0));
    wb = 2; lw = 4; wt = 4 * n; rt = 0;
    forever begin
      for (int o = 0; o < 2 * n; o++) exp_w.push_back((wb << AW) | o);
      for (int o = 0; o < 2 * n; o++) exp_r.push_back((((wb + 1) % 3) << AW) | o);
      for (int o = 0; o < 2 * n; o++) exp_r.push_back((((wb + 2) % 3) << AW) | o);
      wt += 2 * n; rt += 4 * n; lw += 2;
      if (lw == n) begin exp_p.push_back(enc(5, wt, rt)); break; end
      exp_p.push_back(enc(4, wt, rt));
      wb = (wb + 1) % 3;
    end
    for (int o = 0; o < 2 * n; o++) exp_r.push_back((((wb + 2) % 3) << AW) | o);
    for (int o = 0; o < 2 * n; o++) exp_r.push_back((wb << AW) | o);
    rt += 4 * n;
    exp_p.push_back(enc(7, wt, rt));
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {pix_rdy_o, wdata_vld_o, raddr_vld_o, busy_o, err_o, data_sop_o, data_eop_o,
               wsram_2line_o, r2wrsram_o, wrsram_bank_change_o, wr2rsram_o, rsram2idle_o,
               waddr_o, raddr_o}, 0);
  endtask

  // Called at posedge+1; start is driven in the current cycle.
  task automatic run_txn(input logic [3:0] mode, input int n, input bit stall, input int abort);
    int stall_cyc, r_at, ab_cyc;
    bit aborted;
    build_model(|mode[2:0], n);
    obs_w.delete(); obs_r.delete(); obs_p.delete();
    gap_viol = 0; strb_viol = 0; rdy_viol = 0; err_cnt = 0; idle_cnt = 0; r2w_cnt = 0;
    stall_cyc = 0; r_at = 0; ab_cyc = 0; aborted = 1'b0;
    mon_en = 1'b1;
    start_i = 1'b1; mode_i = mode; pic_size_i = 8'(n);
    pix_vld_i = 1'b1; rd_ready_i = 1'b1;
    @(posedge SYS_CLK); #1;
    for (int cyc = 0; cyc < 20000 && idle_cnt == 0 && !aborted; cyc++) begin
      mode_i     = 4'($urandom);
      pic_size_i = 8'($urandom);
      pix_vld_i  = ($urandom_range(0, 3) != 0);
      rd_ready_i = ($urandom_range(0, 3) != 0);
      start_i    = (obs_r.size() < exp_r.size()) && ($urandom_range(0, 15) == 0);
      if (stall && r2w_cnt > 0 && stall_cyc <= 60) begin
        if (stall_cyc == 0) r_at = obs_r.size();
        if (stall_cyc == 60) begin
          chk("stall pix_rdy_o", pix_rdy_o, 0);
          chk("stall raddr_vld_o", raddr_vld_o, 0);
          chk("stall reads issued", obs_r.size() - r_at, 0);
          chk("stall writes done", obs_w.size(), 6 * n);
        end else begin
          rd_ready_i = 1'b0;
          pix_vld_i  = 1'b1;
        end
        stall_cyc++;
      end
      if (abort > 0 && r2w_cnt > 0) begin
        ab_cyc++;
        if (ab_cyc == abort) begin
          mon_en  = 1'b0;
          SYS_RST = 1'b1;
          pix_vld_i = 1'b1; rd_ready_i = 1'b1; start_i = 1'b0;
          @(posedge SYS_CLK); #1;
          chk_all_zero("reset mid-run outputs");
          SYS_RST = 1'b0;
          aborted = 1'b1;
        end
      end
      if (!aborted) begin
        @(posedge SYS_CLK); #1;
      end
    end
    start_i = 1'b0;
    if (aborted) return;
    mon_en = 1'b0;
    chk("completion within budget", idle_cnt, 1);
    chk("busy_o after done", busy_o, 0);
    chk_q("write addresses", obs_w, exp_w);
    chk_q("read addresses", obs_r, exp_r);
    chk_q("pulse sequence", obs_p, exp_p);
    chk("io blocked in pulse cycle", gap_viol, 0);
    chk("wdata_vld_o strobe", strb_viol, 0);
    chk("read without rd_ready_i", rdy_viol, 0);
    chk("err_o during run", err_cnt, 0);
  endtask

  task automatic err_test(input logic [3:0] mode, input int n);
    start_i = 1'b1; mode_i = mode; pic_size_i = 8'(n);
    @(posedge SYS_CLK); #1;
    start_i = 1'b0;
    chk($sformatf("err_o pulse mode=%0h n=%0d", mode, n), err_o, 1);
    chk("busy_o on reject", busy_o, 0);
    chk("data_sop_o on reject", data_sop_o, 0);
    @(posedge SYS_CLK); #1;
    chk("err_o one cycle", err_o, 0);
    chk("busy_o after reject", busy_o, 0);
  endtask

  typedef struct {
    logic [3:0] mode;
    int         n;
    bit         exp_err;
    int         abort;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{4'b0001,   6, 1'b0, 0};
    tbl[1]  = '{4'b0100,   8, 1'b0, 0};
    tbl[2]  = '{4'b0010,   7, 1'b1, 0};
    tbl[3]  = '{4'b0001,   4, 1'b1, 0};
    tbl[4]  = '{4'b0111,   0, 1'b1, 0};
    tbl[5]  = '{4'b0001, 255, 1'b1, 0};
    tbl[6]  = '{4'b1000,   5, 1'b0, 0};
    tbl[7]  = '{4'b1000,   0, 1'b1, 0};
    tbl[8]  = '{4'b0000,   6, 1'b1, 0};
    tbl[9]  = '{4'b1001,   5, 1'b1, 0};
    tbl[10] = '{4'b1010,   6, 1'b0, 0};
    tbl[11] = '{4'b1000,   1, 1'b0, 0};
    tbl[12] = '{4'b0011,  10, 1'b0, 0};
    tbl[13] = '{4'b0001, 254, 1'b0, 3};

    SYS_RST = 1'b1; start_i = 1'b0; mode_i = 4'b0001; pic_size_i = 8'd6;
    pix_vld_i = 1'b1; rd_ready_i = 1'b1;
    repeat (2) @(posedge SYS_CLK);
    #1;
    chk_all_zero("reset outputs");
    SYS_RST = 1'b0;

    foreach (tbl[i]) begin
      if (tbl[i].exp_err) err_test(tbl[i].mode, tbl[i].n);
      else run_txn(tbl[i].mode, tbl[i].n, 1'b0, tbl[i].abort);
      @(posedge SYS_CLK); #1;
    end

    run_txn(4'b0001, 6, 1'b1, 0);
    @(posedge SYS_CLK); #1;

    // Reset mid-STREAM, then an immediate start must behave exactly like a fresh run.
    run_txn(4'b0001, 6, 1'b0, 5);
    run_txn(4'b0001, 6, 1'b0, 0);
    @(posedge SYS_CLK); #1;

    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(0, 1) == 1)
        run_txn({1'($urandom_range(0, 1)), 3'($urandom_range(1, 7))},
                2 * $urandom_range(3, 8), 1'b0, 0);
      else
        run_txn(4'b1000, $urandom_range(1, 30), 1'b0, 0);
      @(posedge SYS_CLK); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
